// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-coded position receiver.
// Pure declarations: no logic, no latency, no flow control.
package gray_pkg;

    localparam int GW = 4;
    localparam int CW = 8;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder (MSB passes through, each lower bit XORs in).
// Zero latency; no flow control.
module gray_to_bin
    import gray_pkg::*;
(
    input  logic [GW-1:0] g,
    output logic [GW-1:0] b
);

    logic acc;

    always_comb begin
        acc       = g[GW-1];
        b         = '0;
        b[GW-1]   = acc;
        for (int i = GW - 2; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
    end

endmodule

// File: rtl/gray_rx_tracker.sv
// Synchronizes a Gray position, decodes it and tracks legal +/-1 steps into pos; illegal steps latch err.
// g-to-b latency 2 cycles (3 with GRAY_RX_SYNC_EN defined: two-flop synchronizer); no backpressure, clr restarts INIT.
module gray_rx_tracker
    import gray_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [GW-1:0] g,
    input  logic          clr,
    output logic [GW-1:0] b,
    output logic          vld,
    output logic          up,
    output logic          dn,
    output logic          wrap,
    output logic          err,
    output logic [CW-1:0] pos
);

    logic [GW-1:0] gs;

`ifdef GRAY_RX_SYNC_EN
    localparam int INIT_LEN = 3;

    logic [GW-1:0] s1_q, s1_d, s2_q, s2_d;

    always_comb begin
        s1_d = g;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign gs = s2_q;
`else
    localparam int INIT_LEN = 2;

    logic [GW-1:0] s1_q, s1_d;

    always_comb s1_d = g;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1_q <= '0;
        else     s1_q <= s1_d;
    end

    assign gs = s1_q;
`endif

    localparam logic [1:0] INIT_LAST = 2'(INIT_LEN - 1);

    logic [GW-1:0] gs_bin;
    logic [GW-1:0] gp_q, gp_d;
    logic [GW-1:0] b_q, b_d;
    logic [GW-1:0] b_inc, b_dec, diff;
    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic          up_q, up_d;
    logic          dn_q, dn_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;
    logic [CW-1:0] pos_q, pos_d;

    gray_to_bin u_dec (
        .g (gs),
        .b (gs_bin)
    );

    // b_q is always the decode of gp_q, so it serves as the previous binary position.
    assign b_inc = b_q + 4'd1;
    assign b_dec = b_q - 4'd1;
    assign diff  = gs ^ gp_q;

    always_comb begin
        gp_d    = gs;
        b_d     = gs_bin;
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        wrap_d  = 1'b0;
        err_d   = err_q;
        pos_d   = pos_q;

        case (state_q)
            INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = TRACK;
                    vld_d   = 1'b1;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            TRACK: begin
                if (diff != '0) begin
                    // A one-bit Gray change that is not an adjacent code is treated as corruption too.
                    if (gs_bin == b_inc) begin
                        up_d   = 1'b1;
                        wrap_d = (b_q == 4'hF);
                        pos_d  = pos_q + 8'd1;
                    end else if (gs_bin == b_dec) begin
                        dn_d   = 1'b1;
                        wrap_d = (b_q == 4'h0);
                        pos_d  = pos_q - 8'd1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FAULT;
                    end
                end
            end
            FAULT: ;
            default: state_d = INIT;
        endcase

        if (clr) begin
            state_d = INIT;
            cnt_d   = 2'd0;
            vld_d   = 1'b0;
            up_d    = 1'b0;
            dn_d    = 1'b0;
            wrap_d  = 1'b0;
            err_d   = 1'b0;
            pos_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gp_q    <= '0;
            b_q     <= '0;
            state_q <= INIT;
            cnt_q   <= 2'd0;
            vld_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            gp_q    <= gp_d;
            b_q     <= b_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
        end
    end

    assign b    = b_q;
    assign vld  = vld_q;
    assign up   = up_q;
    assign dn   = dn_q;
    assign wrap = wrap_q;
    assign err  = err_q;
    assign pos  = pos_q;

endmodule

// File: tb/tb_gray_rx_tracker.sv
// Directed bench for gray_rx_tracker: stimulus queues expected step pulses, a negedge monitor checks them.
module tb_gray_rx_tracker;

`ifdef GRAY_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] g;
    logic [3:0] b;
    logic       vld, up, dn, wrap, err;
    logic [7:0] pos;

    gray_rx_tracker dut (
        .clk  (clk),
        .rst  (rst),
        .g    (g),
        .clr  (clr),
        .b    (b),
        .vld  (vld),
        .up   (up),
        .dn   (dn),
        .wrap (wrap),
        .err  (err),
        .pos  (pos)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] b;
        logic       up;
        logic       dn;
        logic       wrap;
        logic [7:0] pos;
    } exp_t;

    exp_t       q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] gtab [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one Gray value, hold it 4 cycles, check b after the fixed latency.
    task automatic step(input logic [3:0] gv, input logic [3:0] eb, input logic pulse,
                        input logic eup, input logic edn, input logic ewrap, input logic [7:0] epos);
        exp_t e;
        if (pulse) begin
            e.b    = eb;
            e.up   = eup;
            e.dn   = edn;
            e.wrap = ewrap;
            e.pos  = epos;
            q.push_back(e);
        end
        g = gv;
        repeat (LAT) tick();
        chk("b_latency", 32'(b), 32'(eb));
        repeat (4 - LAT) tick();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        if (!rst && (up || dn || wrap)) begin
            a = {b, up, dn, wrap, pos};
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got b=%0d up=%0b dn=%0b wrap=%0b pos=%0h, expected no pulse",
                         b, up, dn, wrap, pos);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL pulse_record: got b=%0d up=%0b dn=%0b wrap=%0b pos=%0h, expected b=%0d up=%0b dn=%0b wrap=%0b pos=%0h",
                             a.b, a.up, a.dn, a.wrap, a.pos, e.b, e.up, e.dn, e.wrap, e.pos);
                end
            end
        end
    end

    initial begin
        gtab[0]  = 4'b0000; gtab[1]  = 4'b0001; gtab[2]  = 4'b0011; gtab[3]  = 4'b0010;
        gtab[4]  = 4'b0110; gtab[5]  = 4'b0111; gtab[6]  = 4'b0101; gtab[7]  = 4'b0100;
        gtab[8]  = 4'b1100; gtab[9]  = 4'b1101; gtab[10] = 4'b1111; gtab[11] = 4'b1110;
        gtab[12] = 4'b1010; gtab[13] = 4'b1011; gtab[14] = 4'b1001; gtab[15] = 4'b1000;

        rst = 1'b1;
        clr = 1'b0;
        g   = 4'b0000;
        #12;
        chk("reset_outputs", 32'({b, vld, up, dn, wrap, err, pos}), 32'd0);

        // Power-up
        tick();
        rst = 1'b0;
        repeat (LAT - 1) tick();
        chk("pwrup_vld_low", 32'(vld), 32'd0);
        tick();
        chk("pwrup_vld_high", 32'(vld), 32'd1);
        chk("pwrup_b", 32'(b), 32'd0);
        chk("pwrup_pos", 32'(pos), 32'd0);
        chk("pwrup_err", 32'(err), 32'd0);

        // Count up through a full revolution
        for (int k = 1; k <= 16; k++)
            step(gtab[k % 16], 4'(k % 16), 1'b1, 1'b1, 1'b0, (k == 16), 8'(k));
        chk("pos_after_up", 32'(pos), 32'd16);

        // Clear, then count down across 0 -> 15 and back
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_pos", 32'(pos), 32'd0);
        chk("clr_vld", 32'(vld), 32'd0);
        repeat (LAT) tick();
        chk("clr_vld_back", 32'(vld), 32'd1);
        step(4'b1000, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        chk("pos_down_wrap", 32'(pos), 32'hFF);
        step(4'b0000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("pos_up_wrap", 32'(pos), 32'h00);

        // Illegal step, then legal steps while faulted
        step(4'b0011, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_pos", 32'(pos), 32'd0);
        step(4'b0010, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(4'b0110, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("fault_err", 32'(err), 32'd1);
        chk("fault_pos", 32'(pos), 32'd0);
        chk("fault_vld", 32'(vld), 32'd1);

        // Clear has priority over a coincident illegal step
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (LAT) tick();
        chk("recover_vld", 32'(vld), 32'd1);
        chk("recover_err", 32'(err), 32'd0);
        g = 4'b0000;
        repeat (LAT - 1) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrpri_err", 32'(err), 32'd0);
        chk("clrpri_pos", 32'(pos), 32'd0);
        chk("clrpri_vld", 32'(vld), 32'd0);
        repeat (LAT - 1) tick();
        chk("clrpri_vld_init", 32'(vld), 32'd0);
        tick();
        chk("clrpri_vld_back", 32'(vld), 32'd1);
        chk("clrpri_err_after", 32'(err), 32'd0);
        chk("clrpri_b", 32'(b), 32'd0);

        // Build pos=5 with err=1, then reset mid-run
        for (int k = 1; k <= 5; k++)
            step(gtab[k], 4'(k), 1'b1, 1'b1, 1'b0, 1'b0, 8'(k));
        step(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05);
        chk("pre_rst_pos", 32'(pos), 32'h05);
        chk("pre_rst_err", 32'(err), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun_rst_outputs", 32'({b, vld, up, dn, wrap, err, pos}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (LAT - 1) tick();
        chk("rerst_vld_low", 32'(vld), 32'd0);
        tick();
        chk("rerst_vld_high", 32'(vld), 32'd1);
        chk("rerst_pos", 32'(pos), 32'd0);
        chk("rerst_err", 32'(err), 32'd0);
        step(4'b0001, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01);

        repeat (4) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
